// File: rtl/uart_fifo_mm.sv
// Memory-mapped UART front end: buffers received and transmitted bytes in
// DEPTH-entry FIFOs and exposes status, data and sticky error flags on port B.
module uart_fifo_mm #(
    parameter int          DEPTH_LOG2 = 4,
    parameter logic [31:0] BASE       = 32'd65544
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr_b,
    input  logic [31:0] data_b_in,
    input  logic [31:0] data_b_we,
    output logic [31:0] data_b,
    output logic        strobe_b,
    input  logic [7:0]  rx_tdata,
    input  logic        rx_tvalid,
    output logic        rx_tready,
    output logic [7:0]  tx_tdata,
    output logic        tx_tvalid,
    input  logic        tx_tready
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = (DEPTH_LOG2)'(1);

    logic [7:0] rx_mem [DEPTH];
    logic [7:0] tx_mem [DEPTH];

    logic [DEPTH_LOG2-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic [DEPTH_LOG2-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic [DEPTH_LOG2:0]   rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
    logic                  rx_overrun_q, rx_overrun_d, tx_drop_q, tx_drop_d;
    logic                  rd_run_q, rd_run_d, strobe_b_q, strobe_b_d;
    logic [31:0]           data_b_q, data_b_d;

    logic [31:0] off;
    logic [1:0]  sel;
    logic        hit, we, rx_full, rx_empty, tx_full, tx_empty;
    logic        rx_rd, tx_wr, fl_wr, rx_push, rx_pop, tx_push, tx_pop;
    logic [31:0] status;
    logic        unused_bits;

    assign off      = addr_b - BASE;
    assign hit      = off < 32'd4;
    assign sel      = off[1:0];
    assign we       = |data_b_we;
    assign rx_full  = rx_cnt_q == CNT_FULL;
    assign rx_empty = rx_cnt_q == '0;
    assign tx_full  = tx_cnt_q == CNT_FULL;
    assign tx_empty = tx_cnt_q == '0;

    assign rx_rd   = hit && sel == 2'd1 && !we;
    assign tx_wr   = hit && sel == 2'd2 && we;
    assign fl_wr   = hit && sel == 2'd3 && we;
    // Only the first cycle of a held RXDATA read consumes a byte.
    assign rx_push = rx_tvalid && !rx_full;
    assign rx_pop  = rx_rd && !rd_run_q && !rx_empty;
    assign tx_push = tx_wr && !tx_full;
    assign tx_pop  = !tx_empty && tx_tready;

    assign status = {8'd0, 8'(tx_cnt_q), 8'(rx_cnt_q),
                     4'd0, tx_drop_q, rx_overrun_q, !tx_full, !rx_empty};
    assign unused_bits = ^data_b_in[31:8];

    assign rx_tready = !rx_full;
    assign tx_tvalid = !tx_empty;
    assign tx_tdata  = tx_mem[tx_rd_q];
    assign data_b    = data_b_q;
    assign strobe_b  = strobe_b_q;

    always_comb begin
        rx_wr_d  = rx_push ? rx_wr_q + PTR_ONE : rx_wr_q;
        rx_rd_d  = rx_pop  ? rx_rd_q + PTR_ONE : rx_rd_q;
        tx_wr_d  = tx_push ? tx_wr_q + PTR_ONE : tx_wr_q;
        tx_rd_d  = tx_pop  ? tx_rd_q + PTR_ONE : tx_rd_q;
        rx_cnt_d = rx_cnt_q;
        case ({rx_push, rx_pop})
            2'b10:   rx_cnt_d = rx_cnt_q + CNT_ONE;
            2'b01:   rx_cnt_d = rx_cnt_q - CNT_ONE;
            default: rx_cnt_d = rx_cnt_q;
        endcase
        tx_cnt_d = tx_cnt_q;
        case ({tx_push, tx_pop})
            2'b10:   tx_cnt_d = tx_cnt_q + CNT_ONE;
            2'b01:   tx_cnt_d = tx_cnt_q - CNT_ONE;
            default: tx_cnt_d = tx_cnt_q;
        endcase
        // A new error event in the same cycle as its clear keeps the flag set.
        rx_overrun_d = (rx_overrun_q && !(fl_wr && data_b_in[0])) || (rx_tvalid && rx_full);
        tx_drop_d    = (tx_drop_q && !(fl_wr && data_b_in[1])) || (tx_wr && tx_full);
        rd_run_d     = rx_rd;
        strobe_b_d   = hit;
        data_b_d     = 32'd0;
        if (hit) begin
            case (sel)
                2'd0: data_b_d = status;
                2'd1: begin
                    if (we)
                        data_b_d = 32'd0;
                    else if (rd_run_q)
                        data_b_d = data_b_q;
                    else if (!rx_empty)
                        data_b_d = {24'd0, rx_mem[rx_rd_q]};
                    else
                        data_b_d = 32'd0;
                end
                2'd2:    data_b_d = 32'd0;
                default: data_b_d = {30'd0, tx_drop_q, rx_overrun_q};
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_wr_q      <= '0;
            rx_rd_q      <= '0;
            tx_wr_q      <= '0;
            tx_rd_q      <= '0;
            rx_cnt_q     <= '0;
            tx_cnt_q     <= '0;
            rx_overrun_q <= 1'b0;
            tx_drop_q    <= 1'b0;
            rd_run_q     <= 1'b0;
            strobe_b_q   <= 1'b0;
            data_b_q     <= 32'd0;
        end else begin
            rx_wr_q      <= rx_wr_d;
            rx_rd_q      <= rx_rd_d;
            tx_wr_q      <= tx_wr_d;
            tx_rd_q      <= tx_rd_d;
            rx_cnt_q     <= rx_cnt_d;
            tx_cnt_q     <= tx_cnt_d;
            rx_overrun_q <= rx_overrun_d;
            tx_drop_q    <= tx_drop_d;
            rd_run_q     <= rd_run_d;
            strobe_b_q   <= strobe_b_d;
            data_b_q     <= data_b_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rx_push)
            rx_mem[rx_wr_q] <= rx_tdata;
        if (tx_push)
            tx_mem[tx_wr_q] <= data_b_in[7:0];
    end
endmodule
